// File: rtl/spi_frame_master.sv
// SPI master engine: variable-length MSB-first frames in all four CPOL/CPHA modes,
// one internal_clk cycle per SCLK half-period, start/busy/done handshake.
module spi_frame_master #(
   parameter int SIZE    = 40,
   parameter int CS_SIZE = 1,
   parameter int LEN_W   = $clog2(SIZE + 1),
   parameter int CS_W    = (CS_SIZE > 1) ? $clog2(CS_SIZE) : 1
) (
   input  logic               internal_clk,
   input  logic               reset_n_in,
   input  logic               start_in,
   input  logic [SIZE-1:0]    data_in,
   input  logic [LEN_W-1:0]   len_in,
   input  logic               cpol_in,
   input  logic               cpha_in,
   input  logic [CS_W-1:0]    cs_select,
   input  logic               miso_in,
   output logic               busy_out,
   output logic               done_out,
   output logic [SIZE-1:0]    data_out,
   output logic               sclk_out,
   output logic               mosi_out,
   output logic [CS_SIZE-1:0] cs_out_n
);

   typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

   localparam logic [LEN_W-1:0] SIZE_L = LEN_W'(SIZE);

   state_t             state_q, state_d;
   logic [SIZE-1:0]    tx_q, tx_d;
   logic [SIZE-1:0]    rx_q, rx_d;
   logic [SIZE-1:0]    data_out_q, data_out_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W:0]     h_q, h_d;
   logic               cpol_q, cpol_d;
   logic               cpha_q, cpha_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               sclk_q, sclk_d;
   logic               mosi_q, mosi_d;
   logic [CS_SIZE-1:0] cs_q, cs_d;

   logic [LEN_W-1:0]   len_c;
   logic [SIZE-1:0]    tx_init;
   logic [CS_SIZE-1:0] cs_sel_n;
   logic               shift_half;
   logic               more_bits;
   logic               last_half;

   // Frame is MSB-aligned in tx so the outgoing bit is always the top bit.
   always_comb begin
      len_c    = (len_in == '0 || len_in > SIZE_L) ? SIZE_L : len_in;
      tx_init  = data_in << (SIZE_L - len_c);
      cs_sel_n = '1;
      for (int i = 0; i < CS_SIZE; i++) cs_sel_n[i] = (cs_select != CS_W'(i));
   end

   // Capture and MOSI advance share one half: even ends for CPHA=0, odd ends for CPHA=1.
   assign shift_half = (h_q[0] == cpha_q);
   assign more_bits  = (h_q[LEN_W:1] != len_q - LEN_W'(1));
   assign last_half  = (h_q == {len_q - LEN_W'(1), 1'b1});

   always_comb begin
      state_d    = state_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      data_out_d = data_out_q;
      len_d      = len_q;
      h_d        = h_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      busy_d     = busy_q;
      done_d     = done_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_d       = cs_q;
      case (state_q)
         IDLE: begin
            sclk_d = cpol_in;
            cs_d   = '1;
            mosi_d = 1'b0;
            busy_d = 1'b0;
            done_d = 1'b0;
            if (start_in) begin
               state_d = SETUP;
               len_d   = len_c;
               cpol_d  = cpol_in;
               cpha_d  = cpha_in;
               tx_d    = tx_init;
               rx_d    = '0;
               h_d     = '0;
               busy_d  = 1'b1;
               cs_d    = cs_sel_n;
               mosi_d  = cpha_in ? 1'b0 : tx_init[SIZE-1];
            end
         end
         SETUP: begin
            state_d = XFER;
            h_d     = '0;
            sclk_d  = ~cpol_q;
            if (cpha_q) mosi_d = tx_q[SIZE-1];
         end
         XFER: begin
            if (shift_half) begin
               rx_d = {rx_q[SIZE-2:0], miso_in};
               if (more_bits) begin
                  tx_d   = tx_q << 1;
                  mosi_d = tx_q[SIZE-2];
               end
            end
            if (last_half) begin
               state_d = HOLD;
               sclk_d  = cpol_q;
            end else begin
               h_d    = h_q + 1'b1;
               sclk_d = cpol_q ^ h_q[0];
            end
         end
         HOLD: begin
            state_d    = DONE;
            cs_d       = '1;
            done_d     = 1'b1;
            data_out_d = rx_q;
            mosi_d     = 1'b0;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge internal_clk or negedge reset_n_in) begin
      if (!reset_n_in) begin
         state_q    <= IDLE;
         tx_q       <= '0;
         rx_q       <= '0;
         data_out_q <= '0;
         len_q      <= SIZE_L;
         h_q        <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_q       <= '1;
      end else begin
         state_q    <= state_d;
         tx_q       <= tx_d;
         rx_q       <= rx_d;
         data_out_q <= data_out_d;
         len_q      <= len_d;
         h_q        <= h_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_q       <= cs_d;
      end
   end

   assign busy_out = busy_q;
   assign done_out = done_q;
   assign data_out = data_out_q;
   assign sclk_out = sclk_q;
   assign mosi_out = mosi_q;
   assign cs_out_n = cs_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Scoreboard bench for spi_frame_master: an edge-driven SPI slave model plus
// per-frame expectations (clamped length, masked data, CS pattern, cycle counts).
module tb_spi_frame_master;

   localparam int SIZE    = 40;
   localparam int CS_SIZE = 3;

   logic              internal_clk = 1'b0;
   logic              reset_n_in;
   logic              start_in;
   logic [SIZE-1:0]   data_in;
   logic [5:0]        len_in;
   logic              cpol_in;
   logic              cpha_in;
   logic [1:0]        cs_select;
   logic              miso;
   logic              busy_out;
   logic              done_out;
   logic [SIZE-1:0]   data_out;
   logic              sclk_out;
   logic              mosi_out;
   logic [CS_SIZE-1:0] cs_out_n;

   always #5 internal_clk = ~internal_clk;

   spi_frame_master #(.SIZE(SIZE), .CS_SIZE(CS_SIZE)) dut (
      .internal_clk(internal_clk),
      .reset_n_in  (reset_n_in),
      .start_in    (start_in),
      .data_in     (data_in),
      .len_in      (len_in),
      .cpol_in     (cpol_in),
      .cpha_in     (cpha_in),
      .cs_select   (cs_select),
      .miso_in     (miso),
      .busy_out    (busy_out),
      .done_out    (done_out),
      .data_out    (data_out),
      .sclk_out    (sclk_out),
      .mosi_out    (mosi_out),
      .cs_out_n    (cs_out_n)
   );

   typedef struct {
      logic [SIZE-1:0]    rx;
      logic [SIZE-1:0]    tx;
      int                 len;
      logic               cpol;
      logic [CS_SIZE-1:0] cs;
      bit                 gap;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Slave: loads its reply at busy rise; shifts on the non-sampling SCLK edge.
   logic [SIZE-1:0] nxt_word, s_word, s_mosi;
   int              nxt_len, s_len, s_sent, s_pulses;
   logic            nxt_cpol, nxt_cpha, s_cpol, s_cpha;

   initial miso = 1'b0;

   always @(posedge busy_out) begin
      s_cpol   = nxt_cpol;
      s_cpha   = nxt_cpha;
      s_len    = nxt_len;
      s_word   = nxt_word;
      s_sent   = 0;
      s_pulses = 0;
      s_mosi   = '0;
      if (!s_cpha) begin
         miso   = s_word[s_len-1];
         s_sent = 1;
      end
   end

   always @(sclk_out) begin
      if (busy_out === 1'b1) begin
         if (sclk_out != s_cpol) begin
            s_pulses++;
            if (!s_cpha) s_mosi = {s_mosi[SIZE-2:0], mosi_out};
            else if (s_sent < s_len) begin
               miso = s_word[s_len-1-s_sent];
               s_sent++;
            end
         end else begin
            if (s_cpha) s_mosi = {s_mosi[SIZE-2:0], mosi_out};
            else if (s_sent < s_len) begin
               miso = s_word[s_len-1-s_sent];
               s_sent++;
            end
         end
      end
   end

   // Monitor: per-frame cycle counts, CS pattern, pops on done_out.
   int                 busy_cnt = 0, cs_cnt = 0, cs_high = 0, last_gap = 0;
   logic [CS_SIZE-1:0] cs_seen;
   bit                 post_done = 0;

   always @(negedge internal_clk) begin
      if (reset_n_in !== 1'b1) begin
         busy_cnt  = 0;
         cs_cnt    = 0;
         cs_high   = 0;
         post_done = 0;
      end else begin
         if (post_done) begin
            chk("busy_after_done", 64'(busy_out), 64'd0);
            chk("done_width", 64'(done_out), 64'd0);
            post_done = 0;
         end
         if (busy_out) busy_cnt++;
         if (cs_out_n != '1) begin
            if (cs_cnt == 0) begin
               last_gap = cs_high;
               if (exp_q.size() > 0) chk("sclk_at_cs_fall", 64'(sclk_out), 64'(exp_q[0].cpol));
            end
            cs_cnt++;
            cs_seen = cs_out_n;
            cs_high = 0;
         end else cs_high++;
         if (done_out) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("data_out", 64'(data_out), 64'(e.rx));
               chk("mosi_word", 64'(s_mosi), 64'(e.tx));
               chk("sclk_pulses", 64'(s_pulses), 64'(e.len));
               chk("busy_cycles", 64'(busy_cnt), 64'(2 * e.len + 3));
               chk("sclk_at_cs_rise", 64'(sclk_out), 64'(e.cpol));
               if (e.cs != '1) begin
                  chk("cs_low_cycles", 64'(cs_cnt), 64'(2 * e.len + 2));
                  chk("cs_pattern", 64'(cs_seen), 64'(e.cs));
                  if (e.gap) chk("cs_gap", 64'(last_gap), 64'd2);
               end else chk("cs_none_low", 64'(cs_cnt), 64'd0);
            end
            busy_cnt  = 0;
            cs_cnt    = 0;
            post_done = 1;
         end
      end
   end

   task automatic send(input logic [SIZE-1:0] d, input int ln, input logic cp, input logic ch,
                       input int sel, input logic [SIZE-1:0] w, input bit gap, input bit hold);
      exp_t               e;
      int                 l;
      logic [63:0]        m;
      bit                 got, prev;
      l         = (ln == 0 || ln > SIZE) ? SIZE : ln;
      m         = (64'd1 << l) - 64'd1;
      data_in   = d;
      len_in    = 6'(ln);
      cpol_in   = cp;
      cpha_in   = ch;
      cs_select = 2'(sel);
      nxt_word  = w;
      nxt_len   = l;
      nxt_cpol  = cp;
      nxt_cpha  = ch;
      e.rx      = w & m[SIZE-1:0];
      e.tx      = d & m[SIZE-1:0];
      e.len     = l;
      e.cpol    = cp;
      e.cs      = (sel < CS_SIZE) ? ~(CS_SIZE'(1) << sel) : '1;
      e.gap     = gap;
      if (!hold) @(negedge internal_clk);
      exp_q.push_back(e);
      start_in = 1'b1;
      prev     = busy_out;
      got      = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge internal_clk);
         if (busy_out && !prev) begin
            got = 1;
            break;
         end
         prev = busy_out;
      end
      if (!got) chk("start_timeout", 64'd0, 64'd1);
      if (!hold) start_in = 1'b0;
   endtask

   task automatic wait_idle();
      bit got = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge internal_clk);
         #1;
         if (exp_q.size() == 0 && !busy_out) begin
            got = 1;
            break;
         end
      end
      chk("idle_timeout", 64'(got), 64'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n_in = 1'b0;
      start_in   = 1'b0;
      data_in    = '0;
      len_in     = '0;
      cpol_in    = 1'b0;
      cpha_in    = 1'b0;
      cs_select  = '0;
      repeat (3) @(negedge internal_clk);
      chk("rst_busy", 64'(busy_out), 64'd0);
      chk("rst_done", 64'(done_out), 64'd0);
      chk("rst_data", 64'(data_out), 64'd0);
      chk("rst_sclk", 64'(sclk_out), 64'd0);
      chk("rst_mosi", 64'(mosi_out), 64'd0);
      chk("rst_cs", 64'(cs_out_n), 64'h7);
      reset_n_in = 1'b1;
      @(negedge internal_clk);

      send(40'hA5, 8, 1'b0, 1'b0, 0, 40'hA5, 0, 0);
      wait_idle();
      for (int md = 1; md < 4; md++) begin
         send(40'h5A, 8, md[1], md[0], 1, 40'h3C, 0, 0);
         wait_idle();
      end
      send(40'hF00000000F, 0,  1'b0, 1'b1, 0, 40'h123456789A, 0, 0);
      wait_idle();
      send(40'hF00000000F, 40, 1'b1, 1'b0, 0, 40'h123456789A, 0, 0);
      wait_idle();

      send(40'h3, 6, 1'b0, 1'b0, 2, 40'h2D, 0, 0);
      wait_idle();
      send(40'h3, 6, 1'b0, 1'b0, 3, 40'h2D, 0, 0);
      wait_idle();

      for (int k = 0; k < 4; k++)
         send(40'($urandom()), 4, 1'b0, 1'b0, 0, 40'($urandom()), k > 0, 1);
      start_in = 1'b0;
      wait_idle();

      // Reset in half 5 of an 8-bit mode-2 frame.
      send(40'hC3, 8, 1'b1, 1'b0, 1, 40'h99, 0, 0);
      repeat (6) @(negedge internal_clk);
      #2 reset_n_in = 1'b0;
      #1;
      chk("midrst_cs", 64'(cs_out_n), 64'h7);
      chk("midrst_sclk", 64'(sclk_out), 64'd0);
      chk("midrst_busy", 64'(busy_out), 64'd0);
      chk("midrst_done", 64'(done_out), 64'd0);
      chk("midrst_data", 64'(data_out), 64'd0);
      exp_q.delete();
      @(negedge internal_clk);
      #2 reset_n_in = 1'b1;
      repeat (30) @(negedge internal_clk);
      send(40'h81, 8, 1'b1, 1'b0, 1, 40'h66, 0, 0);
      wait_idle();

      for (int n = 0; n < 20; n++) begin
         send({$urandom(), $urandom()} & 64'hFF_FFFF_FFFF, $urandom_range(0, 45),
              1'($urandom()), 1'($urandom()), $urandom_range(0, 3),
              {$urandom(), $urandom()} & 64'hFF_FFFF_FFFF, 0, 0);
         wait_idle();
         repeat ($urandom_range(0, 3)) @(negedge internal_clk);
      end

      repeat (5) @(negedge internal_clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
